// File: rtl/opb_err_cnt_bank_pkg.sv
// opb_err_cnt_bank_pkg: register map, CTRL bit positions and handshake state encoding
package opb_err_cnt_bank_pkg;
  localparam logic [7:0] OFF_CNT = 8'h00;
  localparam logic [7:0] OFF_CTRL = 8'h40;
  localparam logic [7:0] OFF_OVF = 8'h44;
  localparam int CTRL_CLR = 31;
  localparam int CTRL_FRZ = 30;
  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
endpackage

// File: rtl/opb_err_cnt_cell.sv
// opb_err_cnt_cell: one saturating error counter with its sticky overflow flag
module opb_err_cnt_cell #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic         ovf_clr,
  output logic [W-1:0] cnt,
  output logic         ovf
);
  logic sat;
  assign sat = &cnt;
  // clear beats everything; an overflow event beats a same-cycle write-1-clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= clr ? '0 : (inc && !sat) ? cnt + 1'b1 : cnt;
      ovf <= clr ? 1'b0 : (inc && sat) ? 1'b1 : ovf_clr ? 1'b0 : ovf;
    end
endmodule

// File: rtl/opb_err_cnt_bank.sv
// opb_err_cnt_bank: OPB slave exposing a bank of saturating error counters with CTRL and OVF registers
module opb_err_cnt_bank
  import opb_err_cnt_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h01080400,
  parameter logic [31:0] C_HIGHADDR = 32'h010804FF,
  parameter int C_NUM_CNT = 4,
  parameter int C_CNT_WIDTH = 32
) (
  input  logic                 OPB_Clk,
  input  logic                 OPB_Rst,
  input  logic [0:31]          OPB_ABus,
  input  logic [0:3]           OPB_BE,
  input  logic [0:31]          OPB_DBus,
  input  logic                 OPB_RNW,
  input  logic                 OPB_select,
  input  logic                 OPB_seqAddr,
  input  logic [C_NUM_CNT-1:0] err_pulse,
  input  logic                 cnt_en,
  output logic [0:31]          Sl_DBus,
  output logic                 Sl_xferAck,
  output logic                 Sl_errAck,
  output logic                 Sl_retry,
  output logic                 Sl_toutSup
);
  state_t state, state_nxt;
  logic hit, acc, wr, clr, freeze;
  logic [7:0] off;
  logic [31:0] rdata, cnt_rd, rd_q;
  logic [C_NUM_CNT-1:0] inc, ovf, ovf_clr;
  logic [C_CNT_WIDTH-1:0] cnt [C_NUM_CNT];
  logic unused;
  assign unused = ^{OPB_seqAddr, OPB_BE[0:2], OPB_ABus[30:31], OPB_DBus};
  assign Sl_errAck = 1'b0;
  assign Sl_retry = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign off = {OPB_ABus[24:29], 2'b00};
  assign hit = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign acc = (state == IDLE) && hit;
  assign wr = acc && !OPB_RNW && OPB_BE[3];
  assign clr = wr && (off == OFF_CTRL) && OPB_DBus[CTRL_CLR];
  assign inc = err_pulse & {C_NUM_CNT{cnt_en && !freeze}};
  always_ff @(posedge OPB_Clk or posedge OPB_Rst)
    if (OPB_Rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? (hit ? ACK : IDLE) : (state == ACK) ? HOLD : IDLE;
  always_comb begin
    Sl_xferAck = (state == ACK);
    Sl_DBus = Sl_xferAck ? rd_q : '0;
  end
  always_ff @(posedge OPB_Clk or posedge OPB_Rst)
    if (OPB_Rst) begin
      freeze <= 1'b0;
      rd_q <= '0;
    end else begin
      if (wr && off == OFF_CTRL) freeze <= OPB_DBus[CTRL_FRZ];
      if (acc) rd_q <= OPB_RNW ? rdata : '0;
    end
  always_comb begin
    ovf_clr = '0;
    for (int i = 0; i < C_NUM_CNT; i++) ovf_clr[i] = wr && (off == OFF_OVF) && OPB_DBus[31-i];
  end
  always_comb begin
    cnt_rd = '0;
    for (int i = 0; i < C_NUM_CNT; i++) if (off == OFF_CNT + 8'(4 * i)) cnt_rd = 32'(cnt[i]);
  end
  assign rdata = (off == OFF_CTRL) ? 32'(freeze) << (31 - CTRL_FRZ) : (off == OFF_OVF) ? 32'(ovf) : cnt_rd;
  for (genvar g = 0; g < C_NUM_CNT; g++) begin : g_cell
    opb_err_cnt_cell #(.W(C_CNT_WIDTH)) u_cell (
      .clk(OPB_Clk),
      .rst(OPB_Rst),
      .inc(inc[g]),
      .clr(clr),
      .ovf_clr(ovf_clr[g]),
      .cnt(cnt[g]),
      .ovf(ovf[g])
    );
  end
endmodule

// File: tb/tb_opb_err_cnt_bank.sv
// tb_opb_err_cnt_bank: directed plus randomized bus/pulse traffic checked against a register-level model
module tb_opb_err_cnt_bank;
  localparam logic [31:0] BASE = 32'h01080400;
  localparam int N = 4;
  localparam int W = 8;
  localparam int MAX = (1 << W) - 1;
  logic OPB_Clk = 1'b0, OPB_Rst = 1'b1;
  logic [0:31] OPB_ABus = '0, OPB_DBus = '0;
  logic [0:3] OPB_BE = '0;
  logic OPB_RNW = 1'b1, OPB_select = 1'b0, OPB_seqAddr = 1'b0, cnt_en = 1'b1;
  logic [N-1:0] err_pulse = '0;
  logic [0:31] Sl_DBus;
  logic Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  int checks = 0, failures = 0;
  int m_cnt [N];
  logic [N-1:0] m_ovf;
  logic m_frz;
  logic wr_pend = 1'b0;
  logic [7:0] wr_off;
  logic [3:0] wr_be;
  logic [31:0] wr_d;
  logic [31:0] got;
  logic [7:0] offs [10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h3C, 8'h40, 8'h44, 8'h45, 8'hFC};

  opb_err_cnt_bank #(.C_NUM_CNT(N), .C_CNT_WIDTH(W)) dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
    .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select), .OPB_seqAddr(OPB_seqAddr),
    .err_pulse(err_pulse), .cnt_en(cnt_en), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
    .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ovf = '0;
    m_frz = 1'b0;
  endtask

  function automatic logic [31:0] mread(input logic [7:0] off);
    logic [7:0] o;
    o = off & 8'hFC;
    if (o < 8'(4 * N)) return 32'(m_cnt[o / 4]);
    if (o == 8'h40) return {30'b0, m_frz, 1'b0};
    if (o == 8'h44) return 32'(m_ovf);
    return 32'h0;
  endfunction

  task automatic model_edge(input logic [N-1:0] p);
    logic w, clr, frz_old;
    logic [7:0] o;
    w = wr_pend && wr_be[0];
    o = wr_off & 8'hFC;
    clr = w && o == 8'h40 && wr_d[0];
    frz_old = m_frz;
    if (w && o == 8'h40) m_frz = wr_d[1];
    for (int i = 0; i < N; i++)
      if (clr) begin
        m_cnt[i] = 0;
        m_ovf[i] = 1'b0;
      end else begin
        if (w && o == 8'h44 && wr_d[i]) m_ovf[i] = 1'b0;
        if (p[i] && cnt_en && !frz_old) begin
          if (m_cnt[i] == MAX) m_ovf[i] = 1'b1;
          else m_cnt[i]++;
        end
      end
  endtask

  task automatic step(input logic [N-1:0] p);
    err_pulse = p;
    @(posedge OPB_Clk);
    model_edge(p);
    wr_pend = 1'b0;
    #1;
    err_pulse = '0;
  endtask

  task automatic bus(input logic [7:0] off, input logic rnw, input logic [3:0] be, input logic [31:0] d,
                     input logic [N-1:0] p, input logic hold, output logic [31:0] rd);
    logic [31:0] exp;
    exp = mread(off);
    OPB_ABus = BASE + 32'(off);
    OPB_RNW = rnw;
    OPB_BE = be;
    OPB_DBus = d;
    OPB_select = 1'b1;
    wr_pend = !rnw;
    wr_off = off;
    wr_be = be;
    wr_d = d;
    step(p);
    rd = Sl_DBus;
    check("ack", 32'(Sl_xferAck), 32'h1);
    if (rnw) check($sformatf("rd_%h", off), Sl_DBus, exp);
    if (!hold) OPB_select = 1'b0;
    step('0);
    check("no_ack", 32'(Sl_xferAck), 32'h0);
    check("dbus_idle", Sl_DBus, 32'h0);
    OPB_select = 1'b0;
    step('0);
  endtask

  task automatic miss(input logic [31:0] addr);
    OPB_ABus = addr;
    OPB_RNW = 1'b1;
    OPB_select = 1'b1;
    step('0);
    check("miss_ack", 32'(Sl_xferAck), 32'h0);
    step('0);
    check("miss_ack2", 32'(Sl_xferAck), 32'h0);
    OPB_select = 1'b0;
  endtask

  initial begin
    logic [7:0] off;
    logic [31:0] d, v0;
    logic rnw;
    model_reset();
    repeat (2) @(posedge OPB_Clk);
    #1;
    check("rst_ack", 32'(Sl_xferAck), 32'h0);
    check("rst_dbus", Sl_DBus, 32'h0);
    OPB_Rst = 1'b0;
    bus(8'h00, 1, 4'hF, 0, '0, 0, got);
    check("first_read", got, 32'h0);
    repeat (5) step(4'b0100);
    bus(8'h08, 1, 4'hF, 0, '0, 0, got);
    check("cnt2_five", got, 32'h5);
    bus(8'h00, 1, 4'hF, 0, '0, 0, got);
    check("cnt0_zero", got, 32'h0);
    repeat (260) step(4'b0001);
    bus(8'h00, 1, 4'hF, 0, '0, 0, got);
    check("cnt0_sat", got, 32'hFF);
    bus(8'h44, 1, 4'hF, 0, '0, 0, got);
    check("ovf_set", got, 32'h1);
    bus(8'h44, 0, 4'hF, 32'h1, '0, 0, got);
    bus(8'h44, 1, 4'hF, 0, '0, 0, got);
    check("ovf_w1c", got, 32'h0);
    bus(8'h40, 0, 4'hF, 32'h1, 4'b0010, 0, got);
    bus(8'h04, 1, 4'hF, 0, '0, 0, got);
    check("clr_wins", got, 32'h0);
    bus(8'h40, 1, 4'hF, 0, '0, 0, got);
    check("ctrl_zero", got, 32'h0);
    bus(8'h40, 0, 4'hF, 32'h2, '0, 0, got);
    bus(8'h0C, 1, 4'hF, 0, '0, 0, v0);
    repeat (3) step(4'b1000);
    bus(8'h0C, 1, 4'hF, 0, '0, 0, got);
    check("frozen", got, v0);
    bus(8'h40, 0, 4'b1110, 32'h0, '0, 0, got);
    bus(8'h40, 1, 4'hF, 0, '0, 0, got);
    check("be_ignored", got, 32'h2);
    bus(8'h40, 0, 4'hF, 32'h0, '0, 0, got);
    miss(BASE - 32'h4);
    miss(32'h01080500);
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 4)) step(N'($urandom));
      cnt_en = ($urandom_range(0, 7) != 0);
      off = offs[$urandom_range(0, 9)];
      rnw = $urandom_range(0, 1) != 0;
      d = $urandom;
      if ((off & 8'hFC) == 8'h40) d = d & ($urandom_range(0, 9) == 0 ? 32'h3 : 32'h2);
      bus(off, rnw, ($urandom_range(0, 3) == 0) ? 4'(~4'b0001 & 4'($urandom)) : 4'(4'b0001 | 4'($urandom)),
          d, N'($urandom), $urandom_range(0, 1) != 0, got);
    end
    for (int i = 0; i < N; i++) begin
      bus(8'(4 * i), 1, 4'hF, 0, '0, 0, got);
      check($sformatf("final_cnt%0d", i), got, 32'(m_cnt[i]));
    end
    cnt_en = 1'b1;
    repeat (4) step(4'b1000);
    OPB_ABus = BASE + 32'h0C;
    OPB_RNW = 1'b1;
    OPB_select = 1'b1;
    step('0);
    check("pre_rst_ack", 32'(Sl_xferAck), 32'h1);
    OPB_Rst = 1'b1;
    #1;
    check("rst_abort_ack", 32'(Sl_xferAck), 32'h0);
    check("rst_abort_dbus", Sl_DBus, 32'h0);
    model_reset();
    OPB_select = 1'b0;
    @(posedge OPB_Clk);
    #1;
    OPB_Rst = 1'b0;
    bus(8'h0C, 1, 4'hF, 0, '0, 0, got);
    check("post_rst_cnt3", got, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/opb_err_cnt_bank.md
OPB_ERR_CNT_BANK -- requirements
Module: opb_err_cnt_bank

Interface
Parameters:
REQ-001 C_BASEADDR, 32'h01080400, first byte address of the slave window.
REQ-002 C_HIGHADDR, 32'h010804FF, last byte address of the slave window.
REQ-003 C_NUM_CNT, 4, number of error counters (1..8).
REQ-004 C_CNT_WIDTH, 32, counter width in bits (8..32); read data zero-extended to 32 bits.
Ports:
REQ-005 OPB_Clk  in  1  sole clock; all logic rising-edge.
REQ-006 OPB_Rst  in  1  reset, asynchronous, active-high.
REQ-007 OPB_ABus  in  [0:31]  bus address, bit 0 MSB.
REQ-008 OPB_BE  in  [0:3]  byte enables; BE[3] covers OPB_DBus[24:31].
REQ-009 OPB_DBus  in  [0:31]  write data.
REQ-010 OPB_RNW  in  1  1 = read, 0 = write.
REQ-011 OPB_select  in  1  transfer request.
REQ-012 OPB_seqAddr  in  1  sequential burst hint; ignored.
REQ-013 err_pulse  in  [C_NUM_CNT-1:0]  one-cycle error strobes, one per counter.
REQ-014 cnt_en  in  1  global count enable.
REQ-015 Sl_DBus  out  [0:31]  read data; all-zero whenever Sl_xferAck is low.
REQ-016 Sl_xferAck  out  1  transfer acknowledge.
REQ-017 Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied to 0.

Function
REQ-018 Hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; offset = OPB_ABus[24:31] word-aligned.
REQ-019 Map: 0x00+4*i counter i (RO); 0x40 CTRL (RW); 0x44 OVF status (R, W1C); all other offsets read 0, writes ignored.
REQ-020 CTRL bit 31 (LSB) = clear pulse (self-clearing, reads 0); bit 30 = freeze; other bits read 0.
REQ-021 Handshake FSM states IDLE, ACK, HOLD; IDLE->ACK on hit; ACK->HOLD unconditionally; HOLD->IDLE unconditionally.
REQ-022 Hit sampled in cycle N gives Sl_xferAck=1 for exactly cycle N+1; no ack in N+2; next hit accepted at N+3 earliest.
REQ-023 Read data is register contents at cycle N, registered onto Sl_DBus in cycle N+1.
REQ-024 Writes commit at the end of cycle N, only when OPB_BE[3]=1; otherwise ignored but still acknowledged.
REQ-025 Counter i increments by 1 when err_pulse[i]=1, cnt_en=1 and freeze=0.
REQ-026 Counter saturates at 2^C_CNT_WIDTH-1; an increment at saturation sets OVF[i] and leaves the counter unchanged.
REQ-027 OVF register: bit 31-i = OVF[i]; write-1 clears; a set event in the same cycle as a clear wins (bit stays 1).
REQ-028 CTRL clear zeroes all counters and OVF bits; it wins over a same-cycle increment (result 0).
REQ-029 Freeze holds counters; clear still acts while frozen.
REQ-030 OPB_select dropping during ACK/HOLD does not alter the FSM sequence.

Reset
REQ-031 OPB_Rst=1 forces immediately: FSM IDLE, Sl_xferAck 0, Sl_DBus 0, counters 0, OVF 0, freeze 0.
REQ-032 Reset mid-transfer aborts it with no ack; the first hit is accepted on the first OPB_Clk edge after reset release.

Structure
REQ-033 Shared package holds the register offsets, CTRL bit positions and FSM state encoding.
REQ-034 Single sub-module opb_err_cnt_cell (one saturating counter with its OVF flag), instantiated C_NUM_CNT times.

Verification
REQ-035 Reset; read 0x00 -> Sl_xferAck one cycle after select, Sl_DBus=0; second ack never in the following cycle.
REQ-036 Pulse err_pulse[2] 5 times, cnt_en=1 -> read 0x08 returns 5; 0x00 returns 0.
REQ-037 C_CNT_WIDTH=8, 260 pulses on counter 0 -> read 0x00 = 0x000000FF, read 0x44 = 0x00000001; write 0x44 data 1 -> 0x44 reads 0.
REQ-038 Write 0x40 data 0x00000001 in the same cycle as err_pulse[1] -> counter 1 reads 0, 0x40 reads 0.
REQ-039 Write 0x40 data 0x00000002, pulse counter 3 three times -> 0x0C unchanged; write BE=4'b1110 -> ignored, still acked.
REQ-040 Assert OPB_Rst during ACK -> Sl_xferAck low at once; read of 0x0C after release returns 0.
